// File: rtl/arb_pkg.sv
// Shared types for the IFU/LSU memory arbiter: FSM encoding, master IDs,
// registered request/response bundles and the default timeout.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_IFU = 2'd1,
    BUSY_LSU = 2'd2,
    RESP     = 2'd3
  } arb_state_e;

  typedef enum logic {
    MASTER_IFU = 1'b0,
    MASTER_LSU = 1'b1
  } master_e;

  localparam int unsigned TIMEOUT_DEFAULT = 255;

  typedef struct packed {
    logic        req_valid;
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } mem_req_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  // Timeout counter is never narrower than 8 bits.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    return (timeout + 1 > 256) ? $clog2(timeout + 1) : 8;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and downstream memory.
interface mem_arbiter_if;
  logic        ifu_reqValid;
  logic [31:0] ifu_raddr;
  logic        ifu_respValid;
  logic [31:0] ifu_rdata;
  logic        ifu_respErr;

  logic        lsu_reqValid;
  logic [31:0] lsu_addr;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_respValid;
  logic [31:0] lsu_rdata;
  logic        lsu_respErr;

  logic        mem_reqValid;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_respValid;
  logic [31:0] mem_rdata;

  modport slave (
    input  ifu_reqValid, ifu_raddr,
    output ifu_respValid, ifu_rdata, ifu_respErr,
    input  lsu_reqValid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    output lsu_respValid, lsu_rdata, lsu_respErr,
    output mem_reqValid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  mem_respValid, mem_rdata
  );

  modport master (
    output ifu_reqValid, ifu_raddr,
    input  ifu_respValid, ifu_rdata, ifu_respErr,
    output lsu_reqValid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    input  lsu_respValid, lsu_rdata, lsu_respErr,
    input  mem_reqValid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output mem_respValid, mem_rdata
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a tie goes to the master not granted last.
module rr_arb2
  import arb_pkg::*;
(
  input  logic [1:0] req,
  input  master_e    last_grant,
  output master_e    grant_id,
  output logic       grant_valid
);
  always_comb begin
    grant_valid = req[0] | req[1];
    grant_id    = MASTER_IFU;
    if (req[0] && req[1]) begin
      grant_id = (last_grant == MASTER_IFU) ? MASTER_LSU : MASTER_IFU;
    end else if (req[1]) begin
      grant_id = MASTER_LSU;
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// IFU/LSU memory arbiter: one outstanding downstream request, registered
// outputs, one-cycle responses and a timeout that returns an error response.
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  localparam int unsigned   CW       = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  arb_state_e    state_q, state_d;
  master_e       last_grant_q, last_grant_d;
  master_e       mask_id_q, mask_id_d;
  master_e       grant_id;
  logic          mask_valid_q, mask_valid_d;
  logic          grant_valid;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    req_masked;
  mem_req_t      mem_req_q, mem_req_d;
  resp_t         ifu_resp_q, ifu_resp_d;
  resp_t         lsu_resp_q, lsu_resp_d;
  resp_t         busy_resp;

  // The master just served is hidden for one IDLE cycle so its still-held
  // request is not taken as a new one.
  assign req_masked[0] = bus.ifu_reqValid & ~(mask_valid_q && mask_id_q == MASTER_IFU);
  assign req_masked[1] = bus.lsu_reqValid & ~(mask_valid_q && mask_id_q == MASTER_LSU);

  rr_arb2 u_rr (
    .req        (req_masked),
    .last_grant (last_grant_q),
    .grant_id   (grant_id),
    .grant_valid(grant_valid)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    mask_valid_d = 1'b0;
    mask_id_d    = mask_id_q;
    cnt_d        = cnt_q;
    mem_req_d    = mem_req_q;
    ifu_resp_d   = '0;
    lsu_resp_d   = '0;
    busy_resp    = '0;
    unique case (state_q)
      IDLE: begin
        if (grant_valid) begin
          last_grant_d        = grant_id;
          cnt_d               = '0;
          mem_req_d.req_valid = 1'b1;
          if (grant_id == MASTER_LSU) begin
            state_d         = BUSY_LSU;
            mem_req_d.addr  = bus.lsu_addr;
            mem_req_d.wen   = bus.lsu_wen;
            mem_req_d.wdata = bus.lsu_wdata;
            mem_req_d.wmask = bus.lsu_wmask;
          end else begin
            state_d         = BUSY_IFU;
            mem_req_d.addr  = bus.ifu_raddr;
            mem_req_d.wen   = 1'b0;
            mem_req_d.wdata = 32'd0;
            mem_req_d.wmask = 4'd0;
          end
        end
      end
      BUSY_IFU, BUSY_LSU: begin
        // A response arriving on the timeout cycle still wins.
        if (bus.mem_respValid || cnt_q == CNT_LAST) begin
          state_d             = RESP;
          cnt_d               = '0;
          mem_req_d.req_valid = 1'b0;
          busy_resp.valid     = 1'b1;
          busy_resp.rdata     = bus.mem_respValid ? bus.mem_rdata : 32'd0;
          busy_resp.err       = ~bus.mem_respValid;
          if (state_q == BUSY_LSU) lsu_resp_d = busy_resp;
          else                     ifu_resp_d = busy_resp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d      = IDLE;
        mask_valid_d = 1'b1;
        mask_id_d    = last_grant_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= MASTER_IFU;
      mask_valid_q <= 1'b0;
      mask_id_q    <= MASTER_IFU;
      cnt_q        <= '0;
      mem_req_q    <= '0;
      ifu_resp_q   <= '0;
      lsu_resp_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      mask_valid_q <= mask_valid_d;
      mask_id_q    <= mask_id_d;
      cnt_q        <= cnt_d;
      mem_req_q    <= mem_req_d;
      ifu_resp_q   <= ifu_resp_d;
      lsu_resp_q   <= lsu_resp_d;
    end
  end

  assign bus.mem_reqValid  = mem_req_q.req_valid;
  assign bus.mem_addr      = mem_req_q.addr;
  assign bus.mem_wen       = mem_req_q.wen;
  assign bus.mem_wdata     = mem_req_q.wdata;
  assign bus.mem_wmask     = mem_req_q.wmask;
  assign bus.ifu_respValid = ifu_resp_q.valid;
  assign bus.ifu_rdata     = ifu_resp_q.rdata;
  assign bus.ifu_respErr   = ifu_resp_q.err;
  assign bus.lsu_respValid = lsu_resp_q.valid;
  assign bus.lsu_rdata     = lsu_resp_q.rdata;
  assign bus.lsu_respErr   = lsu_resp_q.err;

endmodule
